// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the single-port cartridge memory between the CPU
// (PRG space) and the PPU (CHR space). One access issued per cycle, with a
// fixed 3-cycle read latency from the arbitration sample to rvalid.
// Optional build macro CART_MEM_ARB_RR_EN: replaces PPU priority and the
// cpu_wait starvation guard with round-robin arbitration.
module cart_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cart_ready,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic [15:0] ppu_addr,
    input  logic        ppu_wren,
    input  logic [7:0]  ppu_wdata,
    output logic        ppu_ack,
    output logic        ppu_rvalid,
    output logic [7:0]  ppu_rdata,
    output logic [20:0] mem_address,
    output logic        mem_prg_sel,
    output logic        mem_chr_sel,
    output logic        mem_rden,
    output logic        mem_wren,
    output logic [7:0]  mem_write_data,
    input  logic [7:0]  mem_read_data
);

    logic cpu_elig;
    logic ppu_elig;
    logic grant_cpu;
    logic grant_ppu;
    logic rd_tag_cpu;
    logic rd_tag_ppu;

    // A request whose ack is already high is about to be dropped, so it must
    // not be granted a second time.
    assign cpu_elig = cpu_req & cart_ready & ~cpu_ack;
    assign ppu_elig = ppu_req & cart_ready & ~ppu_ack;

`ifdef CART_MEM_ARB_RR_EN
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_PPU = 1'b1
    } req_id_t;

    req_id_t last_grant;

    // Winner selection: on conflict, the requester not granted most recently wins.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ppu = 1'b0;
        if (cpu_elig && ppu_elig) begin
            if (last_grant == REQ_CPU) begin
                grant_ppu = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
        end else begin
            grant_cpu = cpu_elig;
            grant_ppu = ppu_elig;
        end
    end

    // Remember who was granted last; starts as CPU so the PPU wins the first conflict.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= REQ_CPU;
        end else if (grant_cpu) begin
            last_grant <= REQ_CPU;
        end else if (grant_ppu) begin
            last_grant <= REQ_PPU;
        end
    end
`else
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] cpu_wait;

    // Winner selection: PPU priority unless the CPU has lost MAX_WAIT times in a row.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ppu = 1'b0;
        if (cpu_elig && ppu_elig) begin
            if (cpu_wait >= WAIT_LIMIT) begin
                grant_cpu = 1'b1;
            end else begin
                grant_ppu = 1'b1;
            end
        end else begin
            grant_cpu = cpu_elig;
            grant_ppu = ppu_elig;
        end
    end

    // Saturating count of lost arbitrations; holds while cart_ready is low
    // because the CPU is then not eligible and cannot lose.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_wait <= '0;
        end else if (!cpu_req || grant_cpu) begin
            cpu_wait <= '0;
        end else if (cpu_elig && grant_ppu && (cpu_wait != 4'hF)) begin
            cpu_wait <= cpu_wait + 4'd1;
        end
    end
`endif

    // Issue stage: register the winner's access onto the memory bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_ack        <= 1'b0;
            ppu_ack        <= 1'b0;
            mem_prg_sel    <= 1'b0;
            mem_chr_sel    <= 1'b0;
            mem_rden       <= 1'b0;
            mem_wren       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            cpu_ack     <= grant_cpu;
            ppu_ack     <= grant_ppu;
            mem_prg_sel <= grant_cpu;
            mem_chr_sel <= grant_ppu;
            mem_rden    <= (grant_cpu & ~cpu_wren) | (grant_ppu & ~ppu_wren);
            mem_wren    <= (grant_cpu & cpu_wren) | (grant_ppu & ppu_wren);
            if (grant_cpu) begin
                mem_address    <= {5'b0, cpu_addr};
                mem_write_data <= cpu_wdata;
            end else if (grant_ppu) begin
                mem_address    <= {5'b0, ppu_addr};
                mem_write_data <= ppu_wdata;
            end
        end
    end

    // Tag stage: remember which requester owns the read now in the memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_tag_cpu <= 1'b0;
            rd_tag_ppu <= 1'b0;
        end else begin
            rd_tag_cpu <= mem_rden & mem_prg_sel;
            rd_tag_ppu <= mem_rden & mem_chr_sel;
        end
    end

    // Return stage: capture memory data for the tagged requester only.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            ppu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ppu_rdata  <= '0;
        end else begin
            cpu_rvalid <= rd_tag_cpu;
            ppu_rvalid <= rd_tag_ppu;
            if (rd_tag_cpu) begin
                cpu_rdata <= mem_read_data;
            end
            if (rd_tag_ppu) begin
                ppu_rdata <= mem_read_data;
            end
        end
    end

endmodule
